// File: rtl/pcm_nrz_tx_if.sv
// pcm_nrz_tx_if: payload byte valid/ready handshake into the PCM NRZ transmitter
interface pcm_nrz_tx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/pcm_nrz_tx.sv
// pcm_nrz_tx: NRZ PCM frame transmitter, sync word then FRAME_SIZE bytes MSB first
// Optional macro PCM_TX_FRAME_COUNT_EN: payload byte 0 carries an 8-bit frame counter.
module pcm_nrz_tx #(
    parameter int                  CLK_HZ       = 10240000,
    parameter int                  BIT_RATE     = 51200,
    parameter int                  FRAME_SIZE   = 128,
    parameter int                  SYNC_LEN     = 26,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 26'b00000101_01111001_10110111_11,
    parameter logic [7:0]          FILL_BYTE    = 8'h00
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable_i,
    pcm_nrz_tx_if.slave  in_if,
    output logic         txd_o,
    output logic         frame_start_o,
    output logic         underrun_o,
    output logic         busy_o
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;
    localparam int BW  = $clog2(FRAME_SIZE + 1);
    localparam int SW  = $clog2(SYNC_LEN);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sidx_q, sidx_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [7:0]    sh_q, sh_d, buf_q, buf_d, ld_val;
    logic          full_q, full_d, txd_q, txd_d, fs_q, fs_d, un_q, un_d;
    logic [1:0]    rs_q;
    logic          rst_n, tick, ld, take, start;
`ifdef PCM_TX_FRAME_COUNT_EN
    logic [7:0]    fcnt_q, fcnt_d;
`endif

    // reset asserts asynchronously, releases two clocks after reset_n rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rs_q <= '0;
        else          rs_q <= {rs_q[0], 1'b1};
    end

    assign rst_n = rs_q[1];

    // state register and all datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sidx_q  <= '0;
            bidx_q  <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            txd_q   <= 1'b0;
            fs_q    <= 1'b0;
            un_q    <= 1'b0;
`ifdef PCM_TX_FRAME_COUNT_EN
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sidx_q  <= sidx_d;
            bidx_q  <= bidx_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            txd_q   <= txd_d;
            fs_q    <= fs_d;
            un_q    <= un_d;
`ifdef PCM_TX_FRAME_COUNT_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    // bit timing, frame sequencing, shift-register loads and holding buffer
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        sidx_d  = sidx_q;
        bidx_d  = bidx_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        fs_d    = 1'b0;
        un_d    = 1'b0;
        ld      = 1'b0;
        take    = 1'b0;
        start   = 1'b0;
        ld_val  = FILL_BYTE;
`ifdef PCM_TX_FRAME_COUNT_EN
        fcnt_d  = fcnt_q;
`endif
        tick = cnt_q == CW'(CPB - 1);
        if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                txd_d = 1'b0;
                start = enable_i;
            end
            SYNC: if (tick) begin
                if (sidx_q == '0) begin
                    state_d = DATA;
                    byte_d  = '0;
                    ld      = 1'b1;
                end else begin
                    sidx_d = sidx_q - 1'b1;
                    txd_d  = SYNC_PATTERN[sidx_d];
                end
            end
            DATA: if (tick) begin
                if (bidx_q != '0) begin
                    bidx_d = bidx_q - 1'b1;
                    sh_d   = {sh_q[6:0], 1'b0};
                    txd_d  = sh_q[6];
                end else if (byte_q != BW'(FRAME_SIZE - 1)) begin
                    byte_d = byte_q + 1'b1;
                    ld     = 1'b1;
                end else begin
                    state_d = IDLE;
                    txd_d   = 1'b0;
                    start   = enable_i;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = SYNC;
            sidx_d  = SW'(SYNC_LEN - 1);
            txd_d   = SYNC_PATTERN[SYNC_LEN-1];
            fs_d    = 1'b1;
        end
        if (ld) begin
`ifdef PCM_TX_FRAME_COUNT_EN
            if (byte_d == '0) begin
                ld_val = fcnt_q;
                fcnt_d = fcnt_q + 1'b1;
            end else begin
                take   = full_q;
                un_d   = !full_q;
                ld_val = full_q ? buf_q : FILL_BYTE;
            end
`else
            take   = full_q;
            un_d   = !full_q;
            ld_val = full_q ? buf_q : FILL_BYTE;
`endif
            sh_d   = ld_val;
            txd_d  = ld_val[7];
            bidx_d = 3'd7;
        end
        full_d = take ? 1'b0 : (full_q | in_if.data_valid);
        buf_d  = (!full_q && in_if.data_valid) ? in_if.data : buf_q;
    end

    assign in_if.data_ready = !full_q;
    assign txd_o            = txd_q;
    assign frame_start_o    = fs_q;
    assign underrun_o       = un_q;
    assign busy_o           = state_q != IDLE;
endmodule

// File: doc/pcm_nrz_tx.md
Name: pcm_nrz_tx

Overview:
- NRZ PCM frame transmitter: the sending end of the serial PCM link whose receiver bit-syncs, hunts the sync pattern and emits bytes.
- Accepts payload bytes over a valid/ready handshake.
- Serialises each frame MSB-first at BIT_RATE: sync pattern first, then FRAME_SIZE payload bytes.
- Used for loopback and ground-side test of the PCM receive path.

Parameters:
- CLK_HZ, 10240000, system clock frequency in Hz.
- BIT_RATE, 51200, serial bit rate in bits/s; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (200 at defaults).
- FRAME_SIZE, 128, payload bytes per frame.
- SYNC_LEN, 26, sync pattern length in bits.
- SYNC_PATTERN, 26'b00000101_01111001_10110111_11, sync word, sent MSB first.
- FILL_BYTE, 8'h00, byte sent when payload is not available in time.

Ports:
- clk  in  1  system clock, posedge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  transmit enable, sampled only at frame boundaries.
- data  in  8  payload byte.
- data_valid  in  1  data is valid.
- data_ready  out  1  one-byte holding buffer empty; byte accepted when data_valid && data_ready.
- txd  out  1  registered NRZ serial output.
- frame_start  out  1  one-cycle pulse on the first cycle of sync bit SYNC_LEN-1.
- underrun  out  1  one-cycle pulse when FILL_BYTE is substituted.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; txd=0, frame_start=0, underrun=0, busy=0.
  - Holding buffer empty, so data_ready=1.
  - Bit counter, bit index and byte counter cleared.
  - Assertion mid-frame drops txd to 0 immediately and discards the frame.
- Bit timing:
  - Counter 0..CYCLES_PER_BIT-1; bit_tick when count==CYCLES_PER_BIT-1.
  - Every bit holds txd for exactly CYCLES_PER_BIT cycles.
  - Counter held at 0 in IDLE.
- States: IDLE, SYNC, DATA.
- IDLE:
  - txd=0.
  - enable=1 on any cycle -> SYNC on the next cycle; that cycle txd=SYNC_PATTERN[SYNC_LEN-1] and frame_start=1.
- SYNC:
  - Sends SYNC_PATTERN bits SYNC_LEN-1 down to 0, one per bit period.
  - After the bit_tick of bit 0 -> DATA; first payload bit is driven the next cycle.
- DATA:
  - Sends FRAME_SIZE bytes, MSB first.
  - At each byte boundary (the cycle bit 7 is first driven), the shift register loads from the holding buffer.
  - If the buffer is empty at that point: FILL_BYTE is loaded, underrun pulses 1 cycle, and no input byte is consumed.
- End of frame (bit_tick of bit 0 of byte FRAME_SIZE-1):
  - enable=1 -> SYNC directly, no gap; frame_start pulses with the first sync bit.
  - enable=0 -> IDLE, txd=0.
- enable changes mid-frame have no effect until the frame boundary.
- Holding buffer:
  - One entry; data_ready = !full. Fills in any state, including IDLE.
  - Accept sets full.
  - Shift-register load clears full; data_ready rises the cycle after the load.
  - No accept and load in the same cycle, since data_ready is low while full.
- Frame length: (SYNC_LEN + 8*FRAME_SIZE) * CYCLES_PER_BIT cycles = 210000 at defaults.
- Widths:
  - Byte counter sized $clog2(FRAME_SIZE+1) bits.
  - Bit counter sized $clog2(CYCLES_PER_BIT) bits.
  - Sync index sized $clog2(SYNC_LEN) bits.
  - All counters wrap only under explicit compare, never by overflow.

Optional Feature:
- Macro PCM_TX_FRAME_COUNT_EN.
- Defined:
  - Payload byte 0 of every frame is an internal 8-bit frame counter instead of input data.
  - The counter is reset to 0 and increments mod 256 after each frame's byte 0 is loaded.
  - No input byte is consumed and underrun never fires for that slot.
  - The frame then carries FRAME_SIZE-1 input bytes.
- Undefined: all FRAME_SIZE payload bytes come from the input; no counter logic.

Test Plan:
1. Reset with enable=0 -> txd=0, data_ready=1, busy=0, frame_start=0; hold 1000 cycles with no change.
2. enable=1, data 0x00..0x7F always valid -> frame_start once; txd matches SYNC_PATTERN MSB first, 200 cycles per bit; then bytes 0x00..0x7F MSB first; underrun never pulses.
3. Withhold data_valid before payload byte 5 until past its boundary -> byte 5 on line is 0x00, one underrun pulse; the withheld byte goes out as byte 6.
4. enable deasserted during byte 40 -> frame completes all 128 bytes, then txd=0, busy=0 with no further frame_start.
5. enable held high for 3 frames -> frame_start pulses exactly 210000 cycles apart; sync follows the last payload bit with no gap.
6. reset_n asserted mid-byte -> txd=0 and busy=0 asynchronously. After release with enable=1, a fresh frame starts with the sync MSB. With PCM_TX_FRAME_COUNT_EN, byte 0 of successive frames reads 0x00, 0x01, 0x02.
